// File: rtl/hssl_link_ctrl_if.sv
// ============================================================================
// hssl_link_ctrl_if : control/status bundle between the link sequencer and
// its environment.
// Rev 1.0
// ============================================================================
`default_nettype none

interface hssl_link_ctrl_if;
  logic       enable_in;
  logic       restart_in;
  logic [1:0] loss_of_sync_state_in;
  logic       handshake_complete_in;
  logic       version_mismatch_in;
  logic       stop_out;
  logic       loss_reset_out;
  logic       link_up_out;
  logic [2:0] state_out;
  logic [7:0] rst_cnt_out;
  logic [7:0] drop_cnt_out;

  // The sequencer itself is the slave side.
  modport slave (
    input  enable_in, restart_in, loss_of_sync_state_in,
           handshake_complete_in, version_mismatch_in,
    output stop_out, loss_reset_out, link_up_out, state_out,
           rst_cnt_out, drop_cnt_out
  );

  modport master (
    output enable_in, restart_in, loss_of_sync_state_in,
           handshake_complete_in, version_mismatch_in,
    input  stop_out, loss_reset_out, link_up_out, state_out,
           rst_cnt_out, drop_cnt_out
  );
endinterface

`default_nettype wire

// File: rtl/hssl_link_ctrl.sv
// ============================================================================
// hssl_link_ctrl : HSSL link bring-up / recovery sequencer (stop gating,
// RX reset pulses, drop/reset statistics).
// Rev 1.0
// ============================================================================
`default_nettype none

module hssl_link_ctrl #(
  parameter int SYNC_TIMEOUT = 1024,
  parameter int HS_TIMEOUT   = 4096,
  parameter int RST_CYCLES   = 16
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  hssl_link_ctrl_if.slave  lnk
);

  localparam int MAX_SH = (SYNC_TIMEOUT > HS_TIMEOUT) ? SYNC_TIMEOUT : HS_TIMEOUT;
  localparam int MAX_T  = (MAX_SH > RST_CYCLES) ? MAX_SH : RST_CYCLES;
  localparam int TW     = $clog2(MAX_T) + 1;

  localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_TIMEOUT - 1);
  localparam logic [TW-1:0] HS_LAST   = TW'(HS_TIMEOUT - 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_DISABLED  = 3'd0,
    S_WAIT_SYNC = 3'd1,
    S_WAIT_HS   = 3'd2,
    S_LINK_UP   = 3'd3,
    S_RX_RST    = 3'd4,
    S_MISMATCH  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [7:0]    rst_cnt;
  logic [7:0]    drop_cnt;
  logic          stop_r;
  logic          loss_reset_r;
  logic          link_up_r;

  logic          lss_ok;
  logic          timer_clr;
  logic          drop_evt;
  logic          rst_entry;
  logic          timed_state;

  assign lss_ok = (lnk.loss_of_sync_state_in == 2'b00);

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    drop_evt  = 1'b0;
    if (!lnk.enable_in) begin
      state_nxt = S_DISABLED;
    end else begin
      case (state)
        S_DISABLED: state_nxt = S_WAIT_SYNC;
        S_WAIT_SYNC: begin
          // Restart here keeps the state but re-arms the sync timeout.
          if (lnk.restart_in)          timer_clr = 1'b1;
          else if (lss_ok)             state_nxt = S_WAIT_HS;
          else if (timer == SYNC_LAST) state_nxt = S_RX_RST;
        end
        S_WAIT_HS: begin
          if (lnk.restart_in)                  state_nxt = S_WAIT_SYNC;
          else if (lnk.version_mismatch_in)    state_nxt = S_MISMATCH;
          else if (!lss_ok)                    state_nxt = S_WAIT_SYNC;
          else if (lnk.handshake_complete_in)  state_nxt = S_LINK_UP;
          else if (timer == HS_LAST)           state_nxt = S_RX_RST;
        end
        S_LINK_UP: begin
          if (lnk.restart_in)               state_nxt = S_WAIT_SYNC;
          else if (lnk.version_mismatch_in) state_nxt = S_MISMATCH;
          else if (!lss_ok || !lnk.handshake_complete_in) begin
            state_nxt = S_WAIT_SYNC;
            drop_evt  = 1'b1;
          end
        end
        S_RX_RST: begin
          if (lnk.restart_in || timer == RST_LAST) state_nxt = S_WAIT_SYNC;
        end
        S_MISMATCH: begin
          if (lnk.restart_in) state_nxt = S_WAIT_SYNC;
        end
        default: state_nxt = S_DISABLED;
      endcase
    end
  end

  assign rst_entry   = (state_nxt == S_RX_RST) && (state != S_RX_RST);
  assign timed_state = (state == S_WAIT_SYNC) || (state == S_WAIT_HS) ||
                       (state == S_RX_RST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_DISABLED;
      timer        <= '0;
      rst_cnt      <= 8'd0;
      drop_cnt     <= 8'd0;
      stop_r       <= 1'b1;
      loss_reset_r <= 1'b0;
      link_up_r    <= 1'b0;
    end else begin
      state <= state_nxt;

      // Untimed states park the timer at zero so it can never wrap.
      if ((state_nxt != state) || timer_clr || !timed_state) timer <= '0;
      else                                                  timer <= timer + 1'b1;

      if (rst_entry && (rst_cnt != 8'hFF))  rst_cnt  <= rst_cnt + 8'd1;
      if (drop_evt && (drop_cnt != 8'hFF))  drop_cnt <= drop_cnt + 8'd1;

      stop_r       <= (state_nxt != S_LINK_UP);
      loss_reset_r <= (state_nxt == S_RX_RST);
      link_up_r    <= (state_nxt == S_LINK_UP);
    end
  end

  assign lnk.state_out      = state;
  assign lnk.stop_out       = stop_r;
  assign lnk.loss_reset_out = loss_reset_r;
  assign lnk.link_up_out    = link_up_r;
  assign lnk.rst_cnt_out    = rst_cnt;
  assign lnk.drop_cnt_out   = drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hssl_link_ctrl.sv
// ============================================================================
// tb_hssl_link_ctrl : directed scenarios plus randomized run against a
// cycle-level reference model of the link sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hssl_link_ctrl;
  localparam int SYNC_T = 16;
  localparam int HS_T   = 32;
  localparam int RST_C  = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Reference model: state code, cycles spent in current state, counters.
  int ms, mt, mrc, mdc;

  hssl_link_ctrl_if lnk();

  hssl_link_ctrl #(
    .SYNC_TIMEOUT(SYNC_T),
    .HS_TIMEOUT  (HS_T),
    .RST_CYCLES  (RST_C)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .lnk    (lnk)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    ms = 0; mt = 0; mrc = 0; mdc = 0;
  endfunction

  function automatic void model_step();
    int  ns;
    bit  ok;
    bit  rearm;
    ok    = (lnk.loss_of_sync_state_in == 2'b00);
    ns    = ms;
    rearm = 1'b0;
    if (!lnk.enable_in)       ns = 0;
    else if (ms == 0)         ns = 1;
    else if (ms > 5)          ns = 0;
    else if (lnk.restart_in) begin ns = 1; rearm = 1'b1; end
    else begin
      case (ms)
        1: if (ok) ns = 2; else if (mt == SYNC_T - 1) ns = 4;
        2: begin
          if (lnk.version_mismatch_in)        ns = 5;
          else if (!ok)                       ns = 1;
          else if (lnk.handshake_complete_in) ns = 3;
          else if (mt == HS_T - 1)            ns = 4;
        end
        3: begin
          if (lnk.version_mismatch_in) ns = 5;
          else if (!ok || !lnk.handshake_complete_in) begin
            ns = 1;
            if (mdc < 255) mdc++;
          end
        end
        4: if (mt == RST_C - 1) ns = 1;
        default: ;
      endcase
    end
    if (ns == 4 && ms != 4 && mrc < 255) mrc++;
    mt = (ns != ms || rearm) ? 0 : mt + 1;
    ms = ns;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lnk.enable_in             = 1'b0;
    lnk.restart_in            = 1'b0;
    lnk.loss_of_sync_state_in = 2'b10;
    lnk.handshake_complete_in = 1'b0;
    lnk.version_mismatch_in   = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    lnk.enable_in = 1'b1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({lnk.state_out, lnk.stop_out, lnk.loss_reset_out, lnk.link_up_out,
         lnk.rst_cnt_out, lnk.drop_cnt_out} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values got st=%0d stop=%b lrst=%b up=%b rc=%0d dc=%0d want st=0 stop=1 lrst=0 up=0 rc=0 dc=0",
               lnk.state_out, lnk.stop_out, lnk.loss_reset_out, lnk.link_up_out,
               lnk.rst_cnt_out, lnk.drop_cnt_out);
    end
    reset_n = 1'b1;
    idle_inputs();
    model_reset();
  endtask

  task automatic test_bringup();
    apply_reset();
    for (int c = 0; c <= 20; c++) begin
      lnk.enable_in             = 1'b1;
      lnk.loss_of_sync_state_in = (c >= 5)  ? 2'b00 : 2'b10;
      lnk.handshake_complete_in = (c >= 12);
      tick();
      checks++;
      if ({lnk.link_up_out, lnk.stop_out} !== ((c + 1 >= 13) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL bringup cyc %0d got up=%b stop=%b want up=%b", c + 1,
                 lnk.link_up_out, lnk.stop_out, (c + 1 >= 13));
      end
    end
    checks++;
    if ({lnk.rst_cnt_out, lnk.drop_cnt_out} !== 16'd0) begin
      errors++;
      $display("FAIL bringup_counters got rc=%0d dc=%0d want 0 0", lnk.rst_cnt_out, lnk.drop_cnt_out);
    end
  endtask

  task automatic test_no_sync();
    int exp_st, exp_rc;
    apply_reset();
    lnk.enable_in = 1'b1;
    tick();
    for (int k = 0; k < 60; k++) begin
      exp_st = ((k % 20) < 16) ? 1 : 4;
      exp_rc = (k >= 16) ? (k - 16) / 20 + 1 : 0;
      checks++;
      if ({lnk.state_out, lnk.loss_reset_out, lnk.rst_cnt_out} !==
          {3'(exp_st), (exp_st == 4), 8'(exp_rc)}) begin
        errors++;
        $display("FAIL no_sync k=%0d got st=%0d lrst=%b rc=%0d want st=%0d lrst=%b rc=%0d",
                 k, lnk.state_out, lnk.loss_reset_out, lnk.rst_cnt_out,
                 exp_st, (exp_st == 4), exp_rc);
      end
      tick();
    end
  endtask

  task automatic test_drop();
    apply_reset();
    lnk.enable_in = 1'b1;
    lnk.loss_of_sync_state_in = 2'b00;
    lnk.handshake_complete_in = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (lnk.state_out !== 3'd3) begin
      errors++; $display("FAIL drop_linkup got %0d want 3", lnk.state_out);
    end
    lnk.loss_of_sync_state_in = 2'b01;
    tick();
    checks++;
    if ({lnk.state_out, lnk.stop_out, lnk.drop_cnt_out} !== {3'd1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL drop_lss got st=%0d stop=%b dc=%0d want 1 1 1",
               lnk.state_out, lnk.stop_out, lnk.drop_cnt_out);
    end
    lnk.loss_of_sync_state_in = 2'b00;
    tick(); tick();
    checks++;
    if ({lnk.link_up_out, lnk.drop_cnt_out} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL drop_relink got up=%b dc=%0d want 1 1", lnk.link_up_out, lnk.drop_cnt_out);
    end
    lnk.handshake_complete_in = 1'b0;
    tick();
    checks++;
    if ({lnk.state_out, lnk.drop_cnt_out} !== {3'd1, 8'd2}) begin
      errors++;
      $display("FAIL drop_hs got st=%0d dc=%0d want 1 2", lnk.state_out, lnk.drop_cnt_out);
    end
    lnk.handshake_complete_in = 1'b1;
    tick(); tick();
    lnk.restart_in = 1'b1;
    tick();
    lnk.restart_in = 1'b0;
    checks++;
    if ({lnk.state_out, lnk.drop_cnt_out} !== {3'd1, 8'd2}) begin
      errors++;
      $display("FAIL drop_restart got st=%0d dc=%0d want 1 2", lnk.state_out, lnk.drop_cnt_out);
    end
  endtask

  task automatic test_mismatch();
    int bad;
    apply_reset();
    lnk.enable_in = 1'b1;
    lnk.loss_of_sync_state_in = 2'b00;
    tick(); tick();
    lnk.version_mismatch_in = 1'b1;
    tick();
    lnk.version_mismatch_in   = 1'b0;
    lnk.handshake_complete_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      checks++;
      if ({lnk.state_out, lnk.stop_out} !== {3'd5, 1'b1}) begin
        errors++;
        if (bad++ < 5)
          $display("FAIL mismatch_hold cyc %0d got st=%0d stop=%b want 5 1",
                   i, lnk.state_out, lnk.stop_out);
      end
      tick();
    end
    lnk.restart_in = 1'b1;
    tick();
    lnk.restart_in = 1'b0;
    checks++;
    if (lnk.state_out !== 3'd1) begin
      errors++; $display("FAIL mismatch_restart got %0d want 1", lnk.state_out);
    end
  endtask

  task automatic test_saturation();
    int m, exp_rc;
    apply_reset();
    lnk.enable_in = 1'b1;
    tick();
    for (int k = 1; k <= 6020; k++) begin
      tick();
      if (k % 20 == 0) begin
        m = k / 20;
        exp_rc = (m > 255) ? 255 : m;
        checks++;
        if (lnk.rst_cnt_out !== 8'(exp_rc)) begin
          errors++;
          $display("FAIL saturation k=%0d got %0d want %0d", k, lnk.rst_cnt_out, exp_rc);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    lnk.enable_in = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if ({lnk.state_out, lnk.loss_reset_out} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL async_pre got st=%0d lrst=%b want 4 1", lnk.state_out, lnk.loss_reset_out);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({lnk.state_out, lnk.loss_reset_out, lnk.stop_out} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got st=%0d lrst=%b stop=%b want 0 0 1",
               lnk.state_out, lnk.loss_reset_out, lnk.stop_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_disable();
    apply_reset();
    lnk.enable_in = 1'b1;
    lnk.loss_of_sync_state_in = 2'b00;
    tick(); tick(); tick(); tick();
    checks++;
    if (lnk.state_out !== 3'd2) begin
      errors++; $display("FAIL disable_pre got %0d want 2", lnk.state_out);
    end
    lnk.enable_in = 1'b0;
    tick();
    checks++;
    if ({lnk.state_out, lnk.stop_out, lnk.link_up_out} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL disable got st=%0d stop=%b up=%b want 0 1 0",
               lnk.state_out, lnk.stop_out, lnk.link_up_out);
    end
  endtask

  task automatic test_random();
    int mode, okp, hsp, bad;
    logic [21:0] got, exp;
    apply_reset();
    mode = 0; okp = 90; hsp = 95; bad = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        mode = $urandom_range(0, 3);
        case (mode)
          0: begin okp = 95;  hsp = 95; end
          1: begin okp = 50;  hsp = 50; end
          2: begin okp = 3;   hsp = 50; end
          default: begin okp = 100; hsp = 1; end
        endcase
      end
      lnk.enable_in  = ($urandom_range(0, 99) < 98);
      lnk.restart_in = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < okp) lnk.loss_of_sync_state_in = 2'b00;
      else lnk.loss_of_sync_state_in = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      lnk.handshake_complete_in = ($urandom_range(0, 99) < hsp);
      lnk.version_mismatch_in   = (lnk.loss_of_sync_state_in == 2'b00) &&
                                  ($urandom_range(0, 299) == 0);
      tick();
      got = {lnk.state_out, lnk.stop_out, lnk.loss_reset_out, lnk.link_up_out,
             lnk.rst_cnt_out, lnk.drop_cnt_out};
      exp = {3'(ms), (ms != 3), (ms == 4), (ms == 3), 8'(mrc), 8'(mdc)};
      checks++;
      if (got !== exp) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random cyc %0d got %h want %h (st/stop/lrst/up/rc/dc)", i, got, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    idle_inputs();
    test_reset();
    test_bringup();
    test_no_sync();
    test_drop();
    test_mismatch();
    test_disable();
    test_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
